// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// Holds the FSM state encoding and the saturating abort-counter helpers.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam logic [7:0] ABORT_MAX = 8'hFF;

  // Abort counter sticks at full scale so a noisy switch never wraps the debug count.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == ABORT_MAX) ? v : v + 8'd1;
  endfunction

  function automatic logic is_wait(input db_state_t st);
    return (st == WAIT_HIGH) || (st == WAIT_LOW);
  endfunction

endpackage

// File: rtl/button_debouncer_sync_chain.sv
// Reusable multi-flop synchroniser for a single asynchronous bit.
// Pure flop chain with no logic between stages.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronises a raw button input and qualifies level changes with a
// counter-based FSM; db_out feeds the downstream edge detector.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       db_out,
  output logic       busy,
  output logic [7:0] abort_cnt
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (s)
  );

  // busy is the registered decode of the current state, so it trails the
  // state register by one edge and drops on the edge after the accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      db_out    <= 1'b0;
      busy      <= 1'b0;
      abort_cnt <= '0;
    end else begin
      busy <= is_wait(state);
      case (state)
        IDLE_LOW: begin
          cnt <= '0;
          if (s) state <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (!s) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            abort_cnt <= sat_inc(abort_cnt);
          end else if (cnt == CNT_LAST) begin
            state  <= IDLE_HIGH;
            cnt    <= '0;
            db_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE_HIGH: begin
          cnt <= '0;
          if (!s) state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (s) begin
            state     <= IDLE_HIGH;
            cnt       <= '0;
            abort_cnt <= sat_inc(abort_cnt);
          end else if (cnt == CNT_LAST) begin
            state  <= IDLE_LOW;
            cnt    <= '0;
            db_out <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE_LOW;
          cnt    <= '0;
          db_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed and randomized bench for button_debouncer (D=4, S=2) with a
// run-length reference model and a downstream edge-detector monitor.
module tb_button_debouncer;

  localparam int D = 4;
  localparam int S = 2;

  logic       clk;
  logic       rst_n;
  logic       btn_in;
  logic       db_out;
  logic       busy;
  logic [7:0] abort_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .SYNC_STAGES     (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .db_out    (db_out),
    .busy      (busy),
    .abort_cnt (abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: btn delayed by S samples; a new level is accepted once it has
  // differed from the current level for D+1 consecutive samples.
  logic [S-1:0] m_sq;
  logic         m_db;
  logic         m_busy;
  int           m_run;
  int           m_abort;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sq    <= '0;
      m_db    <= 1'b0;
      m_busy  <= 1'b0;
      m_run   <= 0;
      m_abort <= 0;
    end else begin
      m_sq   <= {m_sq[S-2:0], btn_in};
      m_busy <= (m_run > 0);
      if (m_sq[S-1] != m_db) begin
        if (m_run + 1 >= D + 1) begin
          m_db  <= m_sq[S-1];
          m_run <= 0;
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        if (m_run > 0) m_abort <= (m_abort >= 255) ? 255 : m_abort + 1;
        m_run <= 0;
      end
    end
  end

  // Downstream edge detector fed by db_out.
  logic db_q = 1'b0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;
  always @(posedge clk) begin
    db_q <= db_out;
    if (db_out && !db_q) rise_cnt <= rise_cnt + 1;
    if (!db_out && db_q) fall_cnt <= fall_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    chk("model_db_out", db_out, m_db);
    chk("model_busy", busy, m_busy);
    chk("model_abort", abort_cnt, m_abort);
  endtask

  task automatic hold(input logic v, input int n);
    btn_in = v;
    repeat (n) cyc();
  endtask

  int r0, f0, nb;

  initial begin
    rst_n  = 1'b0;
    btn_in = 1'b1;

    // Reset held with button pressed
    #1;
    chk("rst_db_out", db_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", abort_cnt, 0);
    repeat (3) begin
      cyc();
      chk("rst_hold_db_out", db_out, 0);
      chk("rst_hold_busy", busy, 0);
      chk("rst_hold_abort", abort_cnt, 0);
    end
    btn_in = 1'b0;
    rst_n  = 1'b1;
    hold(1'b0, 5);

    // Clean press then clean release
    btn_in = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      cyc();
      chk($sformatf("press_db_e%0d", e), db_out, (e >= 7) ? 1 : 0);
      chk($sformatf("press_busy_e%0d", e), busy, (e >= 4 && e <= 7) ? 1 : 0);
    end
    btn_in = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      cyc();
      chk($sformatf("release_db_e%0d", e), db_out, (e >= 7) ? 0 : 1);
      chk($sformatf("release_busy_e%0d", e), busy, (e >= 4 && e <= 7) ? 1 : 0);
    end
    chk("clean_abort", abort_cnt, 0);

    // Single short bounce
    hold(1'b1, 3);
    hold(1'b0, 10);
    chk("bounce_db_out", db_out, 0);
    chk("bounce_abort", abort_cnt, 1);

    // Boundary: 4 high samples rejected, 5 accepted
    hold(1'b1, 4);
    hold(1'b0, 10);
    chk("bnd4_db_out", db_out, 0);
    chk("bnd4_abort", abort_cnt, 2);
    hold(1'b1, 5);
    btn_in = 1'b0;
    cyc();
    chk("bnd5_db_e6", db_out, 0);
    cyc();
    chk("bnd5_db_e7", db_out, 1);
    hold(1'b0, 12);
    chk("bnd5_released", db_out, 0);
    chk("bnd5_abort", abort_cnt, 2);

    // Reset pulsed mid-qualification (cnt==2 after edge 5)
    hold(1'b1, 5);
    chk("mid_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_db_out", db_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_abort", abort_cnt, 0);
    repeat (2) cyc();
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      cyc();
      if (e == 6) chk("post_rst_db_e6", db_out, 0);
      if (e == 7) chk("post_rst_db_e7", db_out, 1);
    end
    hold(1'b0, 12);

    // Bouncy press and release seen by the edge detector
    r0 = rise_cnt;
    f0 = fall_cnt;
    nb = $urandom_range(2, 5);
    for (int k = 0; k < nb; k++) begin
      hold(1'b1, $urandom_range(1, 3));
      hold(1'b0, $urandom_range(1, 3));
    end
    hold(1'b1, 12);
    nb = $urandom_range(2, 5);
    for (int k = 0; k < nb; k++) begin
      hold(1'b0, $urandom_range(1, 3));
      hold(1'b1, $urandom_range(1, 3));
    end
    hold(1'b0, 12);
    chk("chain_rises", rise_cnt - r0, 1);
    chk("chain_falls", fall_cnt - f0, 1);
    chk("chain_db_low", db_out, 0);

    // Random runs against the reference model
    for (int i = 0; i < 400; i++) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    end
    hold(1'b0, 12);

    // Repeated bounces saturate the abort counter
    for (int i = 0; i < 300; i++) begin
      hold(1'b1, 3);
      hold(1'b0, 4);
    end
    chk("sat_abort", abort_cnt, 8'hFF);
    chk("sat_db_out", db_out, 0);

    rst_n = 1'b0;
    #1;
    chk("final_rst_abort", abort_cnt, 0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
